// File: rtl/mc_controller_if.sv
// mc_controller_if: control bus between the multi-cycle controller and the MIPS datapath/memory
// master (controller): consumes Op, Funct, Zero, Overflow, mem_ack; drives memory handshake,
//   datapath enables, mux selects, ALUctr, Illegal and State.
// slave (datapath side): the mirror image.
interface mc_controller_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic Zero;
  logic Overflow;
  logic mem_ack;
  logic mem_req;
  logic MemWr;
  logic IorD;
  logic IRWr;
  logic PCWr;
  logic [1:0] PCSrc;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic ExtOp;
  logic [2:0] ALUctr;
  logic RegWr;
  logic RegDst;
  logic MemtoReg;
  logic Illegal;
  logic [3:0] State;
  modport master (
    input Op, Funct, Zero, Overflow, mem_ack,
    output mem_req, MemWr, IorD, IRWr, PCWr, PCSrc, ALUSrcA, ALUSrcB, ExtOp, ALUctr,
    output RegWr, RegDst, MemtoReg, Illegal, State
  );
  modport slave (
    output Op, Funct, Zero, Overflow, mem_ack,
    input mem_req, MemWr, IorD, IRWr, PCWr, PCSrc, ALUSrcA, ALUSrcB, ExtOp, ALUctr,
    input RegWr, RegDst, MemtoReg, Illegal, State
  );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control unit (fetch/decode/execute/memory/writeback)
// clk, rst : clock and synchronous active-high reset
// bus      : mc_controller_if.master -- IR fields and ALU flags in, memory handshake,
//            datapath enables, mux selects and ALUctr out
module mc_controller #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2, EXEC_I = 4'd3, MEM_ADDR = 4'd4, MEM_RD = 4'd5,
    MEM_WB = 4'd6, MEM_WR = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ALU_WB = 4'd10
  } state_t;
  state_t st;
  logic [5:0] op_q, fn_q;
  logic ovf_q, ack, r_ok, i_ok, m_ok, legal;
  logic [2:0] alu_r;
  assign ack = !MEM_HANDSHAKE || bus.mem_ack;
  assign r_ok = bus.Op == 6'h00 && bus.Funct inside {6'h21, 6'h20, 6'h23, 6'h22, 6'h2B, 6'h2A, 6'h25};
  assign i_ok = bus.Op inside {6'h0D, 6'h09};
  assign m_ok = bus.Op inside {6'h23, 6'h2B};
  assign legal = r_ok || i_ok || m_ok || bus.Op == 6'h04 || bus.Op == 6'h02;
  assign alu_r = fn_q == 6'h20 ? 3'b001 : fn_q == 6'h25 ? 3'b010 : fn_q == 6'h23 ? 3'b100 :
                 fn_q == 6'h22 ? 3'b101 : fn_q == 6'h2B ? 3'b110 : fn_q == 6'h2A ? 3'b111 : 3'b000;
  always_ff @(posedge clk) begin
    if (rst) st <= FETCH;
    else case (st)
      FETCH:    if (ack) st <= DECODE;
      DECODE: begin
        op_q <= bus.Op;
        fn_q <= bus.Funct;
        st <= r_ok ? EXEC_R : i_ok ? EXEC_I : m_ok ? MEM_ADDR :
              bus.Op == 6'h04 ? BRANCH : bus.Op == 6'h02 ? JUMP : FETCH;
      end
      EXEC_R: begin
        ovf_q <= bus.Overflow;
        st <= ALU_WB;
      end
      EXEC_I:   st <= ALU_WB;
      MEM_ADDR: st <= op_q == 6'h23 ? MEM_RD : MEM_WR;
      MEM_RD:   if (ack) st <= MEM_WB;
      MEM_WR:   if (ack) st <= FETCH;
      default:  st <= FETCH;
    endcase
  end
  // Outputs decode the current state plus the few Mealy terms (ack, Zero, live Op in DECODE);
  // reset blanks everything combinationally so an aborted access never writes PC or registers.
  always_comb begin
    bus.mem_req = 1'b0;
    bus.MemWr = 1'b0;
    bus.IorD = 1'b0;
    bus.IRWr = 1'b0;
    bus.PCWr = 1'b0;
    bus.PCSrc = 2'b00;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00;
    bus.ExtOp = 1'b0;
    bus.ALUctr = 3'b000;
    bus.RegWr = 1'b0;
    bus.RegDst = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.Illegal = 1'b0;
    bus.State = rst ? 4'd0 : st;
    if (!rst) case (st)
      FETCH: begin
        bus.mem_req = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWr = ack;
        bus.PCWr = ack;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b11;
        bus.ExtOp = 1'b1;
        bus.Illegal = !legal;
      end
      EXEC_R: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUctr = alu_r;
        bus.RegDst = 1'b1;
      end
      EXEC_I: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp = op_q != 6'h0D;
        bus.ALUctr = op_q == 6'h0D ? 3'b010 : 3'b000;
      end
      ALU_WB: begin
        bus.RegWr = !(ovf_q && op_q == 6'h00 && fn_q inside {6'h20, 6'h22});
        bus.RegDst = op_q == 6'h00;
      end
      MEM_ADDR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ExtOp = 1'b1;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.IorD = 1'b1;
      end
      MEM_WB: begin
        bus.RegWr = 1'b1;
        bus.MemtoReg = 1'b1;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.IorD = 1'b1;
        bus.MemWr = 1'b1;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUctr = 3'b100;
        bus.PCWr = bus.Zero;
        bus.PCSrc = 2'b01;
      end
      JUMP: begin
        bus.PCWr = 1'b1;
        bus.PCSrc = 2'b10;
      end
      default: ;
    endcase
  end
endmodule
